baud_gen_frac: RTL and testbench
================================

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, meaning ticks per bit; legal values 4, 8, 16.
REQ-003 The block SHALL have parameter NUM_CH, default 1, meaning the number of independent channels; legal range 1..8.
REQ-004 The block SHALL have parameter FRAC_BITS, default 4, meaning the divisor fractional width.
REQ-005 The block SHALL have port clk, input, 1 bit, the clock.
REQ-006 The block SHALL have port arst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-007 The block SHALL have port en, input, NUM_CH bits, the per-channel enable.
REQ-008 The block SHALL have port resync, input, NUM_CH bits, a per-channel phase-restart pulse.
REQ-009 The block SHALL have port baud_sel, input, 4*NUM_CH bits, the per-channel rate select; channel c uses bits [4c+3:4c].
REQ-010 The block SHALL have port div_custom, input, (20+FRAC_BITS)*NUM_CH bits, the per-channel custom divisor in unsigned 20.FRAC_BITS fixed point.
REQ-011 The block SHALL have port tick, output, NUM_CH bits, the oversample tick as a 1-cycle pulse.
REQ-012 The block SHALL have port bit_tick, output, NUM_CH bits, a 1-cycle pulse at each bit boundary.
REQ-013 The block SHALL have port mid_tick, output, NUM_CH bits, a 1-cycle pulse at each bit centre.
REQ-014 The block SHALL have port sel_err, output, NUM_CH bits, the invalid-selection flag.

Function
REQ-015 Channels SHALL be fully independent; each has a state machine with states IDLE, RUN and ERR.
REQ-016 baud_sel values 0..12 SHALL select 1200, 2400, 4800, 9600, 19200, 28800, 38400, 57600, 76800, 115200, 230400, 460800 and 921600 baud, in that order.
- The divisor SHALL be D = round(CLK_FREQ*2^FRAC_BITS/(baud*OVERSAMPLE)), computed at elaboration.
REQ-017 baud_sel value 13 SHALL select D = div_custom of that channel.
REQ-018 A selection SHALL be invalid when baud_sel is 14 or 15, or when the integer part D_int = D>>FRAC_BITS is less than 2.
REQ-019 sel_err SHALL be a register equal to the invalidity of the current selection, with 1-cycle latency, in every state.
REQ-020 Every load SHALL set the period to P = D_int + carry and then set acc to (acc + D_frac) mod 2^FRAC_BITS.
- carry = 1 when acc + D_frac >= 2^FRAC_BITS, else 0.
- D_frac is the low FRAC_BITS bits of D.
REQ-021 In RUN, tick SHALL pulse exactly once every P cycles, and a new load SHALL occur on each tick cycle.
- The long-run average tick period SHALL be D/2^FRAC_BITS cycles.
REQ-022 A sub-counter (0..OVERSAMPLE-1) SHALL increment on each tick and wrap to 0.
- bit_tick SHALL assert with the tick that wraps the sub-counter to 0.
- mid_tick SHALL assert with the tick that brings the sub-counter to OVERSAMPLE/2.
REQ-023 IDLE SHALL hold acc=0, sub-counter=0 and all ticks low.
- In IDLE, en=1 with a valid selection SHALL perform a load and enter RUN; the first tick SHALL occur P cycles after that cycle.
REQ-024 In RUN, en=0 SHALL return the channel to IDLE on the next edge; any tick due in that cycle SHALL be suppressed.
REQ-025 In RUN, resync=1 SHALL clear acc and the sub-counter and perform a fresh load with no tick that cycle.
- The first tick SHALL occur P cycles after the resync cycle.
- resync SHALL take priority over a coincident tick.
REQ-026 Changes to baud_sel or div_custom during RUN SHALL take effect only at the next load; there SHALL be no glitch or truncated period.
REQ-027 If the selection is invalid at a load, the channel SHALL enter ERR with no tick.
- From ERR, a valid selection with en=1 SHALL behave as in REQ-023.
- From ERR, en=0 SHALL return the channel to IDLE.
REQ-028 The tick, bit_tick and mid_tick outputs SHALL be registered.

Reset
REQ-029 While arst_n=0, all channels SHALL be in IDLE, with all counters and acc at 0 and tick, bit_tick, mid_tick and sel_err all 0.
REQ-030 Reset SHALL take effect immediately, including mid-period, and operation SHALL restart per REQ-023 after release.

Verification
REQ-031 CLK_FREQ=100e6, OVERSAMPLE=16, sel=9, en rise -> tick periods 54,54,54,55 repeating; bit_tick every 16th tick; mid_tick on the 8th tick after each bit_tick.
REQ-032 sel=3 -> D=10417 (D_int=651, D_frac=1); 16 consecutive tick periods total 10417 cycles, with exactly one period of 652.
REQ-033 resync pulsed mid-period and coincident with a tick -> no tick that cycle; next tick 54 cycles later; sub-counter restarted (bit_tick on the 16th tick).
REQ-034 sel 9->4 changed mid-period -> current period completes at the old length; following periods are 325/326 cycles (D=5208).
REQ-035 sel=14, or sel=13 with div_custom=0x00010 -> sel_err=1 after 1 cycle, no ticks; sel set to 9 -> sel_err=0 and RUN per REQ-023.
REQ-036 NUM_CH=2 with different sels, and arst_n asserted mid-run -> channels produce independent tick sequences; reset clears all outputs immediately.

Source files
------------

// File: rtl/baud_gen_frac.sv
// Fractional-N baud tick generator with NUM_CH independent channels.
// Each channel divides clk by a 20.FRAC_BITS fixed-point divisor chosen from
// a baud table (computed at elaboration) or a per-channel custom value, and
// emits oversample ticks plus bit-boundary and bit-centre strobes.
module baud_gen_frac #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int NUM_CH     = 1,
  parameter int FRAC_BITS  = 4
) (
  input  logic                              clk,
  input  logic                              arst_n,
  input  logic [NUM_CH-1:0]                 en,
  input  logic [NUM_CH-1:0]                 resync,
  input  logic [4*NUM_CH-1:0]               baud_sel,
  input  logic [(20+FRAC_BITS)*NUM_CH-1:0]  div_custom,
  output logic [NUM_CH-1:0]                 tick,
  output logic [NUM_CH-1:0]                 bit_tick,
  output logic [NUM_CH-1:0]                 mid_tick,
  output logic [NUM_CH-1:0]                 sel_err
);

  localparam int DW = 20 + FRAC_BITS;   // full divisor width
  localparam int IW = 20;               // integer part width
  localparam int PW = 21;               // period counter width (P can reach 2^20)
  localparam int SW = $clog2(OVERSAMPLE);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ERR = 2'd2} state_t;

  function automatic logic [DW-1:0] calc_div(input longint baud);
    longint num;
    longint den;
    num = longint'(CLK_FREQ) * (longint'(1) << FRAC_BITS);
    den = baud * longint'(OVERSAMPLE);
    return DW'((num + den / 2) / den);
  endfunction

  // Entries 13..15 are placeholders: 13 is replaced by div_custom, 14/15 are invalid.
  localparam logic [DW-1:0] DIV_TAB [16] = '{
    calc_div(1200),   calc_div(2400),   calc_div(4800),   calc_div(9600),
    calc_div(19200),  calc_div(28800),  calc_div(38400),  calc_div(57600),
    calc_div(76800),  calc_div(115200), calc_div(230400), calc_div(460800),
    calc_div(921600), '0, '0, '0
  };

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [3:0]           sel;
    logic [DW-1:0]        custom;
    logic [DW-1:0]        div;
    logic [IW-1:0]        d_int;
    logic [FRAC_BITS-1:0] d_frac;
    logic                 invalid;
    logic                 fresh;
    logic                 load;
    logic [FRAC_BITS-1:0] acc_base;
    logic [FRAC_BITS:0]   sum;
    logic [PW-1:0]        period;
    logic [SW-1:0]        sub_inc;

    state_t               state_q, state_d;
    logic [FRAC_BITS-1:0] acc_q, acc_d;
    logic [PW-1:0]        cnt_q, cnt_d;
    logic [SW-1:0]        sub_q, sub_d;
    logic                 tick_q, tick_d;
    logic                 bit_q, bit_d;
    logic                 mid_q, mid_d;
    logic                 err_q;

    assign sel    = baud_sel[4*c +: 4];
    assign custom = div_custom[DW*c +: DW];

    // Divisor decode, validity and the fractional-accumulator load arithmetic.
    always_comb begin
      div      = (sel == 4'd13) ? custom : DIV_TAB[sel];
      d_int    = div[DW-1:FRAC_BITS];
      d_frac   = div[FRAC_BITS-1:0];
      invalid  = (sel >= 4'd14) || (d_int < IW'(2));
      // A load from IDLE/ERR or a resync starts from zero phase.
      fresh    = (state_q != RUN) || resync[c];
      acc_base = fresh ? '0 : acc_q;
      sum      = {1'b0, acc_base} + {1'b0, d_frac};
      period   = {1'b0, d_int} + PW'(sum[FRAC_BITS]);
      sub_inc  = (sub_q == SW'(OVERSAMPLE - 1)) ? '0 : sub_q + SW'(1);
    end

    // Next-state and next-datapath logic for the channel FSM.
    always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sub_d   = sub_q;
      tick_d  = 1'b0;
      bit_d   = 1'b0;
      mid_d   = 1'b0;
      load    = 1'b0;
      unique case (state_q)
        RUN: begin
          if (!en[c]) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            sub_d   = '0;
          end else if (resync[c]) begin
            load  = 1'b1;
            sub_d = '0;
          end else if (cnt_q == '0) begin
            load = 1'b1;
            if (!invalid) begin
              tick_d = 1'b1;
              sub_d  = sub_inc;
              bit_d  = (sub_inc == '0);
              mid_d  = (sub_inc == SW'(OVERSAMPLE / 2));
            end
          end else begin
            cnt_d = cnt_q - PW'(1);
          end
        end
        default: begin
          acc_d = '0;
          cnt_d = '0;
          sub_d = '0;
          if (!en[c]) state_d = IDLE;
          else        load    = 1'b1;
        end
      endcase
      // The divisor is sampled only here, so rate changes never truncate a period.
      if (load) begin
        if (invalid) begin
          state_d = ERR;
          acc_d   = '0;
          cnt_d   = '0;
          sub_d   = '0;
        end else begin
          state_d = RUN;
          acc_d   = sum[FRAC_BITS-1:0];
          cnt_d   = period - PW'(1);
        end
      end
    end

    // Channel state register.
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state_q <= IDLE;
      else         state_q <= state_d;
    end

    // Accumulator, counters and registered strobes.
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        acc_q  <= '0;
        cnt_q  <= '0;
        sub_q  <= '0;
        tick_q <= 1'b0;
        bit_q  <= 1'b0;
        mid_q  <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        acc_q  <= acc_d;
        cnt_q  <= cnt_d;
        sub_q  <= sub_d;
        tick_q <= tick_d;
        bit_q  <= bit_d;
        mid_q  <= mid_d;
        err_q  <= invalid;
      end
    end

    assign tick[c]     = tick_q;
    assign bit_tick[c] = bit_q;
    assign mid_tick[c] = mid_q;
    assign sel_err[c]  = err_q;
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac with two channels. The reference model tracks each
// channel's ideal tick time as a fixed-point timestamp (ticks land on the
// integer part of a running sum of D), alongside directed period checks.
module tb_baud_gen_frac;
  localparam int NCH = 2;
  localparam int FB  = 4;
  localparam int OS  = 16;

  logic        clk = 1'b0;
  logic        arst_n = 1'b1;
  logic [1:0]  en = '0;
  logic [1:0]  resync = '0;
  logic [7:0]  baud_sel = '0;
  logic [47:0] div_custom = '0;
  logic [1:0]  tick, bit_tick, mid_tick, sel_err;

  baud_gen_frac #(.CLK_FREQ(100_000_000), .OVERSAMPLE(OS), .NUM_CH(NCH), .FRAC_BITS(FB)) dut (
    .clk(clk), .arst_n(arst_n), .en(en), .resync(resync), .baud_sel(baud_sel),
    .div_custom(div_custom), .tick(tick), .bit_tick(bit_tick), .mid_tick(mid_tick),
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  int bauds [13] = '{1200, 2400, 4800, 9600, 19200, 28800, 38400, 57600,
                     76800, 115200, 230400, 460800, 921600};

  // model: 0 = off, 1 = running, 2 = error
  int     mode [NCH];
  longint tpos [NCH];
  longint nxt  [NCH];
  int     tcnt [NCH];

  // observation of the DUT
  longint last [NCH];
  int     per_q [NCH][$];
  int     obs_ticks [NCH];
  int     first_bit [NCH];
  int     first_mid [NCH];

  function automatic longint dval(logic [3:0] s, logic [23:0] cu);
    real r;
    if (s == 4'd13) return longint'(cu);
    if (s > 4'd12) return -1;
    r = 100.0e6 * 16.0 / (real'(bauds[s]) * 16.0);
    return longint'($rtoi(r + 0.5));
  endfunction

  function automatic int qget(int c, int i);
    if (i < per_q[c].size()) return per_q[c][i];
    return -1;
  endfunction

  task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mark(int c, longint start);
    per_q[c].delete();
    last[c]      = start;
    obs_ticks[c] = 0;
    first_bit[c] = -1;
    first_mid[c] = -1;
  endtask

  task automatic start_ch(int c, longint n, longint d, bit v);
    if (v) begin
      mode[c] = 1;
      tpos[c] = n * 16 + d;
      nxt[c]  = tpos[c] >>> FB;
      tcnt[c] = 0;
    end else begin
      mode[c] = 2;
    end
  endtask

  task automatic step();
    longint n, d;
    bit v, et, eb, em, ee;
    @(negedge clk);
    n = cyc;
    for (int c = 0; c < NCH; c++) begin
      et = 0; eb = 0; em = 0; ee = 0;
      if (!arst_n) begin
        mode[c] = 0;
      end else begin
        d  = dval(baud_sel[4*c +: 4], div_custom[24*c +: 24]);
        v  = (d >= 32);
        ee = !v;
        if (mode[c] == 1) begin
          if (!en[c]) mode[c] = 0;
          else if (resync[c]) start_ch(c, n, d, v);
          else if (n == nxt[c]) begin
            if (v) begin
              et = 1;
              tcnt[c]++;
              eb = (tcnt[c] % OS == 0);
              em = (tcnt[c] % OS == OS / 2);
              tpos[c] += d;
              nxt[c] = tpos[c] >>> FB;
            end else begin
              mode[c] = 2;
            end
          end
        end else if (!en[c]) begin
          mode[c] = 0;
        end else begin
          start_ch(c, n, d, v);
        end
      end
      chk($sformatf("tick%0d@%0d", c, n), tick[c], et);
      chk($sformatf("bit%0d@%0d", c, n), bit_tick[c], eb);
      chk($sformatf("mid%0d@%0d", c, n), mid_tick[c], em);
      chk($sformatf("err%0d@%0d", c, n), sel_err[c], ee);
      if (tick[c] === 1'b1) begin
        if (last[c] >= 0) per_q[c].push_back(int'(n - last[c]));
        last[c] = n;
        obs_ticks[c]++;
        if (bit_tick[c] === 1'b1 && first_bit[c] < 0) first_bit[c] = obs_ticks[c];
        if (mid_tick[c] === 1'b1 && first_mid[c] < 0) first_mid[c] = obs_ticks[c];
      end
    end
  endtask

  task automatic run(int k);
    repeat (k) step();
  endtask

  initial begin
    int g, sum, n652, old_len, r;
    for (int c = 0; c < NCH; c++) begin
      mode[c] = 0; tpos[c] = 0; nxt[c] = 0; tcnt[c] = 0;
      mark(c, -1);
    end
    #1 arst_n = 1'b0;
    run(3);
    arst_n = 1'b1;

    // ch0 at 115200, ch1 at 9600, enabled together
    baud_sel = {4'd3, 4'd9};
    en = 2'b11;
    mark(0, cyc + 1);
    mark(1, cyc + 1);
    run(10417 + 30);
    for (int i = 0; i < 8; i++)
      chk($sformatf("p115k_%0d", i), qget(0, i), (i % 4 == 3) ? 55 : 54);
    chk("first_bit_115k", first_bit[0], 16);
    chk("first_mid_115k", first_mid[0], 8);
    sum = 0; n652 = 0;
    for (int i = 0; i < 16; i++) begin
      sum += qget(1, i);
      if (qget(1, i) == 652) n652++;
    end
    chk("sum16_9600", sum, 10417);
    chk("n652_9600", n652, 1);

    // resync coincident with a due tick on ch0
    for (g = 0; g < 200 && !(mode[0] == 1 && nxt[0] == cyc + 1); g++) step();
    chk("align_resync", (mode[0] == 1 && nxt[0] == cyc + 1), 1);
    resync = 2'b01;
    mark(0, cyc + 1);
    step();
    resync = '0;
    run(16 * 55 + 10);
    chk("resync_p0", qget(0, 0), 54);
    chk("resync_bit", first_bit[0], 16);
    chk("resync_mid", first_mid[0], 8);

    // resync somewhere mid-period
    run($urandom_range(3, 40));
    resync = 2'b01;
    mark(0, cyc + 1);
    step();
    resync = '0;
    run(60);
    chk("resync_mid_p0", qget(0, 0), 54);

    // rate change 115200 -> 19200 mid-period on ch0
    for (g = 0; g < 100 && !(mode[0] == 1 && nxt[0] > cyc + 3 && cyc - last[0] > 2); g++) step();
    chk("align_selchg", (mode[0] == 1 && nxt[0] > cyc + 3 && cyc - last[0] > 2), 1);
    old_len = int'(nxt[0] - last[0]);
    chk("old_len_range", (old_len == 54 || old_len == 55), 1);
    baud_sel[3:0] = 4'd4;
    per_q[0].delete();
    run(60 + 326 * 5);
    chk("selchg_old", qget(0, 0), old_len);
    chk("selchg_p1", (qget(0, 1) == 325 || qget(0, 1) == 326), 1);
    chk("selchg_pair12", qget(0, 1) + qget(0, 2), 651);
    chk("selchg_pair34", qget(0, 3) + qget(0, 4), 651);

    // invalid selections on ch1
    en[1] = 1'b0;
    step();
    baud_sel[7:4] = 4'd14;
    en[1] = 1'b1;
    mark(1, -1);
    step();
    chk("sel14_err", sel_err[1], 1);
    run(100);
    chk("sel14_noticks", obs_ticks[1], 0);
    baud_sel[7:4] = 4'd13;
    div_custom[47:24] = 24'h000010;
    step();
    chk("cust_small_err", sel_err[1], 1);
    run(60);
    chk("cust_small_noticks", obs_ticks[1], 0);
    baud_sel[7:4] = 4'd9;
    mark(1, cyc + 1);
    step();
    chk("recover_err", sel_err[1], 0);
    run(60);
    chk("recover_p0", qget(1, 0), 54);

    // randomized enables, resyncs and selections
    for (int it = 0; it < 60; it++) begin
      for (int c = 0; c < NCH; c++) begin
        r = $urandom_range(0, 15);
        if (r < 2) en[c] = ~en[c];
        else if (r < 4) resync[c] = 1'b1;
        else if (r < 7) begin
          baud_sel[4*c +: 4] = 4'($urandom_range(5, 15));
          if (baud_sel[4*c +: 4] == 4'd13) div_custom[24*c +: 24] = 24'($urandom_range(0, 1024));
        end
      end
      step();
      resync = '0;
      run($urandom_range(1, 150));
    end

    // asynchronous reset while ch0 tick is high and ch1 flags an error
    baud_sel = {4'd14, 4'd9};
    en = 2'b11;
    run(5);
    for (g = 0; g < 200 && tick[0] !== 1'b1; g++) step();
    chk("tick_before_rst", tick[0], 1);
    chk("err_before_rst", sel_err[1], 1);
    #2 arst_n = 1'b0;
    #1;
    chk("rst_tick", tick, 0);
    chk("rst_bit", bit_tick, 0);
    chk("rst_mid", mid_tick, 0);
    chk("rst_err", sel_err, 0);
    run(3);
    arst_n = 1'b1;
    mark(0, cyc + 1);
    run(60);
    chk("post_rst_p0", qget(0, 0), 54);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
